// File: rtl/vmem_console_ctrl.sv
// Text-console write controller: buffers ASCII bytes, owns the cursor and is the sole writer of character memory.
// Define CONSOLE_CLR_LINE_EN to blank the destination row on every newline.
module vmem_console_ctrl #(
    parameter int COLS       = 70,
    parameter int ROWS       = 30,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key_in,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       clr_req,
    output logic       busy,
    output logic       mem_we,
    output logic [6:0] mem_x,
    output logic [4:0] mem_y,
    output logic [7:0] mem_wdata,
    output logic [6:0] cur_x,
    output logic [4:0] cur_y
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [6:0]    X_LAST   = 7'(COLS - 1);
    localparam logic [4:0]    Y_LAST   = 5'(ROWS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef CONSOLE_CLR_LINE_EN
    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;
`else
    typedef enum logic {CLR_ALL, IDLE} state_t;
`endif

    state_t state, state_n;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_n;
    logic          push, pop, fifo_empty;

    logic [6:0] sweep_x, sx_n, cx_n, wx_n;
    logic [4:0] sweep_y, sy_n, cy_n, wy_n;
    logic [7:0] wd_n, pend_byte, pend_byte_n;
    logic       we_n, pend_valid, pend_valid_n, newline;

    assign push       = key_valid && key_ready;
    assign fifo_empty = (count == '0);
    assign count_n    = count + CW'(push) - CW'(pop);

    // NOTE: storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= key_in;
    end

    // A popped byte sits in pend_byte for one cycle before it is decoded.
    always_comb begin
        // NOTE: every signal written here is given a default first so no path infers a latch.
        state_n      = state;
        sx_n         = sweep_x;
        sy_n         = sweep_y;
        cx_n         = cur_x;
        cy_n         = cur_y;
        we_n         = 1'b0;
        wx_n         = mem_x;
        wy_n         = mem_y;
        wd_n         = mem_wdata;
        pend_valid_n = pend_valid;
        pend_byte_n  = pend_byte;
        pop          = 1'b0;
        newline      = 1'b0;

        case (state)
            CLR_ALL: begin
                we_n = 1'b1;
                wx_n = sweep_x;
                wy_n = sweep_y;
                wd_n = 8'h00;
                if (sweep_x == X_LAST) begin
                    sx_n = '0;
                    if (sweep_y == Y_LAST) begin
                        sy_n    = '0;
                        cx_n    = '0;
                        cy_n    = '0;
                        state_n = IDLE;
                    end else begin
                        sy_n = sweep_y + 5'd1;
                    end
                end else begin
                    sx_n = sweep_x + 7'd1;
                end
            end

`ifdef CONSOLE_CLR_LINE_EN
            CLR_LINE: begin
                // The cursor already sits on the row being blanked.
                we_n = 1'b1;
                wx_n = sweep_x;
                wy_n = cur_y;
                wd_n = 8'h00;
                if (sweep_x == X_LAST) begin
                    sx_n    = '0;
                    state_n = IDLE;
                end else begin
                    sx_n = sweep_x + 7'd1;
                end
            end
`endif

            IDLE: begin
                if (clr_req && !busy) begin
                    state_n = CLR_ALL;
                    sx_n    = '0;
                    sy_n    = '0;
                end else begin
                    if (pend_valid) begin
                        pend_valid_n = 1'b0;
                        if (pend_byte >= 8'h20 && pend_byte <= 8'h7E) begin
                            we_n = 1'b1;
                            wx_n = cur_x;
                            wy_n = cur_y;
                            wd_n = pend_byte;
                            if (cur_x == X_LAST) newline = 1'b1;
                            else                 cx_n    = cur_x + 7'd1;
                        end else if (pend_byte == 8'h0A || pend_byte == 8'h0D) begin
                            newline = 1'b1;
                        end else if (pend_byte == 8'h08) begin
                            if (cur_x != '0) begin
                                cx_n = cur_x - 7'd1;
                                we_n = 1'b1;
                                wx_n = cur_x - 7'd1;
                                wy_n = cur_y;
                                wd_n = 8'h00;
                            end else if (cur_y != '0) begin
                                cx_n = X_LAST;
                                cy_n = cur_y - 5'd1;
                                we_n = 1'b1;
                                wx_n = X_LAST;
                                wy_n = cur_y - 5'd1;
                                wd_n = 8'h00;
                            end
                        end
                    end

                    if (newline) begin
                        cx_n = '0;
                        cy_n = (cur_y == Y_LAST) ? 5'd0 : cur_y + 5'd1;
`ifdef CONSOLE_CLR_LINE_EN
                        state_n = CLR_LINE;
                        sx_n    = '0;
`endif
                    end

`ifdef CONSOLE_CLR_LINE_EN
                    pop = !fifo_empty && !clr_req && !newline;
`else
                    pop = !fifo_empty && !clr_req;
`endif
                    if (pop) begin
                        pend_valid_n = 1'b1;
                        pend_byte_n  = fifo_mem[rd_ptr];
                    end
                end
            end

            default: state_n = CLR_ALL;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (reset) begin
            state      <= CLR_ALL;
            sweep_x    <= '0;
            sweep_y    <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            mem_we     <= 1'b0;
            mem_x      <= '0;
            mem_y      <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            key_ready  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pend_valid <= 1'b0;
            pend_byte  <= '0;
        end else begin
            state      <= state_n;
            sweep_x    <= sx_n;
            sweep_y    <= sy_n;
            cur_x      <= cx_n;
            cur_y      <= cy_n;
            mem_we     <= we_n;
            mem_x      <= wx_n;
            mem_y      <= wy_n;
            mem_wdata  <= wd_n;
            // busy lines up with the sweep's write strobes.
            busy       <= (state != IDLE);
            key_ready  <= (count_n != FULL_CNT);
            count      <= count_n;
            pend_valid <= pend_valid_n;
            pend_byte  <= pend_byte_n;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: tb/tb_vmem_console_ctrl.sv
// Self-checking bench for vmem_console_ctrl: console-level model predicts the ordered cell writes and cursor.
module tb_vmem_console_ctrl;

    localparam int COLS = 70;
    localparam int ROWS = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic       clr_req;
    logic       busy;
    logic       mem_we;
    logic [6:0] mem_x;
    logic [4:0] mem_y;
    logic [7:0] mem_wdata;
    logic [6:0] cur_x;
    logic [4:0] cur_y;

    vmem_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .clr_req(clr_req), .busy(busy), .mem_we(mem_we), .mem_x(mem_x), .mem_y(mem_y),
        .mem_wdata(mem_wdata), .cur_x(cur_x), .cur_y(cur_y)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    // Model: expected writes packed {x[6:0], y[4:0], data[7:0]} in order, plus the cursor.
    logic [19:0] exp_q[$];
    int mx = 0;
    int my = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic void exp_write(input int x, input int y, input logic [7:0] d);
        exp_q.push_back({7'(x), 5'(y), d});
    endfunction

    function automatic void model_newline();
        mx = 0;
        my = (my == ROWS - 1) ? 0 : my + 1;
`ifdef CONSOLE_CLR_LINE_EN
        for (int x = 0; x < COLS; x++) exp_write(x, my, 8'h00);
`endif
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_write(mx, my, b);
            if (mx == COLS - 1) model_newline();
            else mx++;
        end else if (b == 8'h0A || b == 8'h0D) begin
            model_newline();
        end else if (b == 8'h08) begin
            if (mx > 0) begin
                mx--;
                exp_write(mx, my, 8'h00);
            end else if (my > 0) begin
                mx = COLS - 1;
                my--;
                exp_write(mx, my, 8'h00);
            end
        end
    endfunction

    function automatic void model_clear_all();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) exp_write(x, y, 8'h00);
        mx = 0;
        my = 0;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        mx = 0;
        my = 0;
    endfunction

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 60)      return 8'($urandom_range(32, 126));
        else if (r < 70) return 8'h0A;
        else if (r < 75) return 8'h0D;
        else if (r < 90) return 8'h08;
        else             return 8'($urandom_range(127, 255));
    endfunction

    // Compare process: every write strobe must match the next predicted write.
    always @(negedge clk) begin
        logic [19:0] e;
        if (busy === 1'b1) busy_cnt++;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got x=%0d y=%0d d=%0h expected no write", mem_x, mem_y, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("mem_write", {12'h0, mem_x, mem_y, mem_wdata}, {12'h0, e});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bit acc = 0;
        int tries = 0;
        while (!acc && tries < 200) begin
            @(negedge clk);
            key_in    = b;
            key_valid = 1'b1;
            acc       = key_ready;
            tries++;
            @(posedge clk);
        end
        #1 key_valid = 1'b0;
        if (acc) model_byte(b);
        else fail_now("send_timeout");
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 8 && n < 6000) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0 && mem_we === 1'b0) quiet++;
            else quiet = 0;
        end
        if (quiet < 8) fail_now("idle_timeout");
        check("pending_writes", exp_q.size(), 0);
    endtask

    task automatic check_cursor(input string name, input int ex, input int ey);
        check({name, "_x"}, cur_x, ex);
        check({name, "_y"}, cur_y, ey);
    endtask

    initial begin
        logic [7:0] six [6];
        int idx, ones, first, last, base;
        bit acc;

        six = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        reset = 1'b1;
        key_in = 8'h00;
        key_valid = 1'b0;
        clr_req = 1'b0;

        // Reset: two cycles, then values must be at their reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_xy", {mem_x, mem_y, mem_wdata}, 0);
        check("rst_cursor", {cur_x, cur_y}, 0);
        check("rst_key_ready", key_ready, 0);
        model_reset();
        model_clear_all();
        reset = 1'b0;
        busy_cnt = 0;

        // Hold six bytes during the power-up sweep: only four fit.
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            key_valid = (idx < 6);
            if (idx < 6) key_in = six[idx];
            acc = key_valid && key_ready;
            @(posedge clk);
            if (acc) begin
                model_byte(six[idx]);
                idx++;
            end
        end
        #1 key_valid = 1'b0;
        @(negedge clk);
        check("accepted_during_sweep", idx, 4);
        check("key_ready_full", key_ready, 0);

        base = 0;
        while (busy === 1'b1 && base < 3000) begin
            @(negedge clk);
            base++;
        end
        if (busy !== 1'b0) fail_now("sweep_timeout");
        check("sweep_busy_cycles", busy_cnt, COLS * ROWS);
        ones = 0; first = -1; last = -1;
        for (int c = 0; c < 10; c++) begin
            if (mem_we === 1'b1) begin
                ones++;
                if (first < 0) first = c;
                last = c;
            end
            @(negedge clk);
        end
        check("queued_write_count", ones, 4);
        check("queued_writes_back_to_back", last - first, 3);
        wait_idle();
        check_cursor("cur_after_abcd", 4, 0);

        // clr_req wins over a same-cycle pop; FIFO bytes survive the sweep.
        @(negedge clk);
        check("key_ready_idle", key_ready, 1);
        key_in = 8'h50; key_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_in = 8'h51; clr_req = 1'b1;
        @(posedge clk);
        #1 key_valid = 1'b0; clr_req = 1'b0;
        model_clear_all();
        model_byte(8'h50);
        model_byte(8'h51);
        repeat (50) @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        wait_idle();
        check_cursor("cur_after_clr_pq", 2, 0);

        // Plain clear, then first-byte latency.
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        model_clear_all();
        wait_idle();
        send(8'h41);
        @(negedge clk);
        check("lat_k", mem_we, 0);
        @(negedge clk);
        check("lat_k1", mem_we, 0);
        @(negedge clk);
        check("lat_k2", {mem_we, mem_x, mem_y, mem_wdata}, {1'b1, 7'd0, 5'd0, 8'h41});
        wait_idle();
        check_cursor("cur_after_A", 1, 0);

        // End-of-line wrap from (69,3).
        repeat (3) send(8'h0A);
        repeat (69) send(8'h78);
        wait_idle();
        check_cursor("cur_at_69_3", 69, 3);
        base = busy_cnt;
        send(8'h42);
        wait_idle();
        check_cursor("cur_after_wrap", 0, 4);
`ifdef CONSOLE_CLR_LINE_EN
        check("line_clear_busy", busy_cnt - base, COLS);
`else
        check("line_clear_busy", busy_cnt - base, 0);
`endif

        // Row wrap, backspace at origin, backspace across a row.
        repeat (25) send(8'h0D);
        wait_idle();
        check_cursor("cur_at_0_29", 0, 29);
        send(8'h0A);
        wait_idle();
        check_cursor("cur_row_wrap", 0, 0);
        send(8'h08);
        wait_idle();
        check_cursor("cur_bs_origin", 0, 0);
        repeat (5) send(8'h0A);
        send(8'h08);
        wait_idle();
        check_cursor("cur_bs_row", 69, 4);

        // Randomized byte stream with random valid gaps.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            key_valid = ($urandom_range(0, 1) == 1);
            key_in = rand_byte();
            acc = key_valid && key_ready;
            @(posedge clk);
            if (acc) model_byte(key_in);
        end
        #1 key_valid = 1'b0;
        wait_idle();
        check_cursor("cur_after_random", mx, my);

        // Reset in the middle of a sweep restarts the full clear.
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        model_clear_all();
        repeat (300) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        model_clear_all();
        base = busy_cnt;
        @(negedge clk);
        check("midsweep_rst_we", mem_we, 0);
        reset = 1'b0;
        wait_idle();
        check("midsweep_busy_cycles", busy_cnt - base, COLS * ROWS);
        check_cursor("cur_after_rst", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
